// File: rtl/serial_tx_pkg.sv
// Shared constants and helpers for the buffered serial transmitter.
package serial_tx_pkg;

  // Transmit FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of bits on the wire per frame: data bits plus optional parity bit
  function automatic int frame_len(input int width, input int parity_en);
    return width + ((parity_en != 0) ? 32'sd1 : 32'sd0);
  endfunction

endpackage

// File: rtl/tx_frame_fifo.sv
// Synchronous frame FIFO: registered level, full/empty derived from the level,
// sticky overflow when a push arrives while full.
module tx_frame_fifo
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             overflow_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // full uses the registered level, so a pop in the same cycle never makes room
  assign full_s    = (level_r == LW'(DEPTH));
  assign empty_s   = (level_r == {LW{1'b0}});
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Frame storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of two), level and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (push & full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = level_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/serial_tx_buffered.sv
// Buffered serial transmitter: queues frames in a FIFO and shifts them out one
// bit per rising edge of the divided bit clock, singly or as a back-to-back burst.
module serial_tx_buffered
  import serial_tx_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 0,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       sample,
  input  logic                       startTx,
  input  logic                       burst,
  input  logic                       clkTx,
  output logic                       dout,
  output logic                       txBusy,
  output logic                       txDone,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int FB = frame_len(WIDTH, PARITY_EN);
  localparam int CW = $clog2(FB);

  logic [1:0]       state_r;
  logic             clk_tx_q_r;
  logic             burst_r;
  logic [FB-1:0]    frame_r;
  logic [CW-1:0]    bit_cnt_r;
  logic             dout_r;
  logic             tx_busy_r;
  logic             tx_done_r;

  logic             tick_s;
  logic             pop_s;
  logic             empty_s;
  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] ordered_s;
  logic [FB-1:0]    frame_s;

  // Even parity: XOR of all data bits
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  assign tick_s = clkTx & ~clk_tx_q_r;
  assign pop_s  = (state_r == ST_LOAD);

  tx_frame_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (sample),
    .pop      (pop_s),
    .din      (dataIn),
    .head     (head_s),
    .full     (full),
    .empty    (empty_s),
    .level    (level),
    .overflow (overflow)
  );

  // Arrange the FIFO head so frame_s[0] is the first bit on the wire, parity last
  always_comb begin
    ordered_s = head_s;
    for (int i = 0; i < WIDTH; i++) begin
      ordered_s[i] = (MSB_FIRST != 0) ? head_s[WIDTH-1-i] : head_s[i];
    end
    frame_s                = {FB{1'b0}};
    frame_s[WIDTH-1:0]     = ordered_s;
    frame_s[FB-1]          = (PARITY_EN != 0) ? even_parity(head_s) : ordered_s[WIDTH-1];
  end

  // Register the bit clock so its rising edge can be detected in the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_tx_q_r <= 1'b0;
    end else begin
      clk_tx_q_r <= clkTx;
    end
  end

  // Transmit FSM with shifter; dout/txBusy/txDone are driven from registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      burst_r   <= 1'b0;
      frame_r   <= {FB{1'b0}};
      bit_cnt_r <= {CW{1'b0}};
      dout_r    <= 1'b0;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (startTx && !empty_s) begin
            state_r   <= ST_LOAD;
            burst_r   <= burst;
            tx_busy_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          // a tick landing here is deliberately ignored
          frame_r   <= frame_s;
          bit_cnt_r <= {CW{1'b0}};
          dout_r    <= frame_s[0];
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick_s) begin
            if (bit_cnt_r == CW'(FB - 1)) begin
              state_r   <= ST_DONE;
              dout_r    <= 1'b0;
              tx_done_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + CW'(1);
              frame_r   <= {1'b0, frame_r[FB-1:1]};
              dout_r    <= frame_r[1];
            end
          end
        end
        ST_DONE: begin
          if (burst_r && !empty_s) begin
            state_r <= ST_LOAD;
          end else begin
            state_r   <= ST_IDLE;
            tx_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          dout_r    <= 1'b0;
          tx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign dout   = dout_r;
  assign txBusy = tx_busy_r;
  assign txDone = tx_done_r;
  assign empty  = empty_s;

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Bench for serial_tx_buffered: two instances (LSB-first/no parity and
// MSB-first/even parity) share stimulus and are compared every cycle against a
// frame-queue reference model, plus a directed vector table and corner sequences.
module tb_serial_tx_buffered;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SHIFT = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sample, startTx, burst, clkTx;
  logic [7:0] dataIn;
  logic       dout_a, busy_a, done_a, full_a, empty_a, ovf_a;
  logic       dout_b, busy_b, done_b, full_b, empty_b, ovf_b;
  logic [2:0] level_a, level_b;

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx_buffered #(.WIDTH(8), .DEPTH(4), .PARITY_EN(0), .MSB_FIRST(0)) dut_a (
    .clk(clk), .reset(reset), .dataIn(dataIn), .sample(sample), .startTx(startTx),
    .burst(burst), .clkTx(clkTx), .dout(dout_a), .txBusy(busy_a), .txDone(done_a),
    .full(full_a), .empty(empty_a), .level(level_a), .overflow(ovf_a));

  serial_tx_buffered #(.WIDTH(8), .DEPTH(4), .PARITY_EN(1), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .dataIn(dataIn), .sample(sample), .startTx(startTx),
    .burst(burst), .clkTx(clkTx), .dout(dout_b), .txBusy(busy_b), .txDone(done_b),
    .full(full_b), .empty(empty_b), .level(level_b), .overflow(ovf_b));

  // ---------------- reference model (per instance k) ----------------
  int         fbk  [2] = '{8, 9};
  int         msbk [2] = '{0, 1};
  int         st   [2];
  int         pos  [2];
  int         hd   [2];
  int         cnt  [2];
  logic [7:0] cur  [2];
  logic       bl   [2];
  logic       ovf  [2];
  logic [7:0] mem  [2][4];
  logic       m_ctq;

  function automatic logic exp_bit(input int k, input logic [7:0] d, input int p);
    if (p >= 8) return ^d;
    else if (msbk[k] != 0) return d[7-p];
    else return d[p];
  endfunction

  task automatic model_step();
    logic tk, push_ok, pop;
    int   c0;
    tk = clkTx && !m_ctq;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        st[k] = M_IDLE; pos[k] = 0; hd[k] = 0; cnt[k] = 0; ovf[k] = 1'b0; bl[k] = 1'b0;
      end else begin
        c0      = cnt[k];
        push_ok = sample && (c0 < 4);
        pop     = 1'b0;
        if (sample && c0 == 4) ovf[k] = 1'b1;
        case (st[k])
          M_IDLE:  if (startTx && c0 > 0) begin st[k] = M_LOAD; bl[k] = burst; end
          M_LOAD:  begin cur[k] = mem[k][hd[k]]; pos[k] = 0; pop = 1'b1; st[k] = M_SHIFT; end
          M_SHIFT: if (tk) begin
                     if (pos[k] == fbk[k] - 1) st[k] = M_DONE;
                     else pos[k] = pos[k] + 1;
                   end
          default: st[k] = (bl[k] && c0 > 0) ? M_LOAD : M_IDLE;
        endcase
        if (push_ok) mem[k][(hd[k] + c0) % 4] = dataIn;
        if (pop) hd[k] = (hd[k] + 1) % 4;
        cnt[k] = c0 + (push_ok ? 1 : 0) - (pop ? 1 : 0);
      end
    end
    m_ctq = reset ? 1'b0 : clkTx;
  endtask

  task automatic check_all();
    logic [8:0] got, expv;
    logic       ed;
    for (int k = 0; k < 2; k++) begin
      got = (k == 0) ? {dout_a, busy_a, done_a, full_a, empty_a, level_a, ovf_a}
                     : {dout_b, busy_b, done_b, full_b, empty_b, level_b, ovf_b};
      ed  = (st[k] == M_SHIFT) ? exp_bit(k, cur[k], pos[k]) : 1'b0;
      expv = {ed, st[k] != M_IDLE, st[k] == M_DONE, cnt[k] == 4, cnt[k] == 0, 3'(cnt[k]), ovf[k]};
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL model_cycle dut%0d t=%0t dout/busy/done/full/empty/level/ovf got %b required %b",
                 k, $time, got, expv);
      end
    end
  endtask

  // One clock: model consumes the inputs held across the edge, outputs sampled at negedge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sample = 1'b0; startTx = 1'b0; burst = 1'b0; clkTx = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    sample = 1'b1; dataIn = d;
    cycle();
    sample = 1'b0;
  endtask

  task automatic start(input logic b);
    startTx = 1'b1; burst = b;
    cycle();
    startTx = 1'b0; burst = 1'b0;
  endtask

  // ---------------- directed vector table (checked on dut_a) ----------------
  typedef struct {
    logic       rst, smp;
    logic [7:0] d;
    logic       stt, bu, ck;
    logic       e_dout, e_busy, e_done;
    logic [2:0] e_lvl;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input logic rst, input logic smp, input logic [7:0] d,
                         input logic stt, input logic bu, input logic ck,
                         input logic ed, input logic eb, input logic edn, input logic [2:0] el);
    vec_t v;
    v.rst = rst; v.smp = smp; v.d = d; v.stt = stt; v.bu = bu; v.ck = ck;
    v.e_dout = ed; v.e_busy = eb; v.e_done = edn; v.e_lvl = el;
    vt.push_back(v);
  endtask

  initial begin
    logic [7:0] pat;
    logic       bits_b [$];
    logic [8:0] got9;
    int         ticks, dn_a, dn_b;
    logic       seen, fin;

    reset = 1'b1; sample = 1'b0; startTx = 1'b0; burst = 1'b0; clkTx = 1'b0; dataIn = 8'h00;
    m_ctq = 1'b0;
    @(negedge clk);

    // Push 0xA5, single start; tick during LOAD ignored; clkTx held high = one advance
    pat = 8'hA5;
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0);
    add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 3'd1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  pat[0], 1'b1, 1'b0, 3'd0);
    for (int r = 0; r < 3; r++)
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, pat[0], 1'b1, 1'b0, 3'd0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  pat[0], 1'b1, 1'b0, 3'd0);
    for (int b = 1; b < 8; b++) begin
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, pat[b], 1'b1, 1'b0, 3'd0);
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, pat[b], 1'b1, 1'b0, 3'd0);
    end
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b1, 3'd0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; sample = vt[i].smp; dataIn = vt[i].d;
      startTx = vt[i].stt; burst = vt[i].bu; clkTx = vt[i].ck;
      cycle();
      n_checks++;
      if ({dout_a, busy_a, done_a, level_a} !== {vt[i].e_dout, vt[i].e_busy, vt[i].e_done, vt[i].e_lvl}) begin
        n_fail++;
        $display("FAIL vec[%0d] dout/busy/done/level got %b required %b", i,
                 {dout_a, busy_a, done_a, level_a},
                 {vt[i].e_dout, vt[i].e_busy, vt[i].e_done, vt[i].e_lvl});
      end
    end

    // MSB-first with parity: 0x07 -> 0,0,0,0,0,1,1,1 then parity 1; nine ticks
    do_reset();
    push(8'h07);
    start(1'b0);
    cycle();
    ticks = 0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      bits_b.push_back(dout_b);
      clkTx = 1'b1; cycle(); ticks++;
      if (done_b) seen = 1'b1;
      clkTx = 1'b0; cycle();
    end
    got9 = '0;
    for (int i = 0; i < bits_b.size() && i < 9; i++) got9[8-i] = bits_b[i];
    check("parity_frame_done", 32'(seen), 32'd1);
    check("parity_frame_ticks", 32'(ticks), 32'd9);
    check("parity_frame_bits", 32'(got9), 32'b0_0000_1111);

    // Overflow then burst drain of four frames
    do_reset();
    sample = 1'b1;
    dataIn = 8'h11; cycle();
    dataIn = 8'h22; cycle();
    dataIn = 8'h33; cycle();
    dataIn = 8'h44; cycle();
    dataIn = 8'h55; cycle();
    sample = 1'b0;
    check("ovf_full_level", {29'd0, full_a, ovf_a, (level_a == 3'd4)}, 32'd7);
    start(1'b1);
    dn_a = 0; dn_b = 0; fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      clkTx = ~clkTx; cycle();
      if (done_a) dn_a++;
      if (done_b) dn_b++;
      if (!busy_a && !busy_b && empty_a && empty_b) fin = 1'b1;
    end
    check("burst_finished", 32'(fin), 32'd1);
    check("burst_done_a", 32'(dn_a), 32'd4);
    check("burst_done_b", 32'(dn_b), 32'd4);

    // startTx while empty is ignored; startTx during SHIFT is ignored
    do_reset();
    start(1'b0);
    cycle();
    check("start_empty", {30'd0, busy_a, dout_a}, 32'd0);
    push(8'h3C);
    push(8'h5A);
    start(1'b0);
    dn_a = 0; dn_b = 0;
    for (int i = 0; i < 40; i++) begin
      startTx = (i == 6); burst = (i == 6);
      clkTx = ~clkTx; cycle();
      if (done_a) dn_a++;
      if (done_b) dn_b++;
    end
    startTx = 1'b0; burst = 1'b0;
    check("start_in_shift_done_a", 32'(dn_a), 32'd1);
    check("start_in_shift_done_b", 32'(dn_b), 32'd1);
    check("start_in_shift_level", 32'(level_a), 32'd1);

    // Reset mid-frame after three ticks aborts without txDone, then normal frame
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h81 + 8'(i));
    start(1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      clkTx = 1'b1; cycle();
      clkTx = 1'b0; cycle();
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    check("midframe_reset", {27'd0, dout_a, busy_a, done_a, ovf_a, (level_a != 3'd0)}, 32'd0);
    push(8'hC3);
    start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      clkTx = ~clkTx; cycle();
      if (done_a) seen = 1'b1;
    end
    check("after_reset_frame", 32'(seen), 32'd1);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      sample  = ($urandom_range(0, 2) == 0);
      dataIn  = 8'($urandom);
      startTx = ($urandom_range(0, 7) == 0);
      burst   = 1'($urandom);
      if ($urandom_range(0, 2) == 0) clkTx = ~clkTx;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_buffered.md
Name: serial_tx_buffered

Overview:
- Parametrised successor to the calculator's single-frame serial transceiver.
- Buffers up to DEPTH result frames in an internal FIFO and shifts them out one bit per clkTx rising edge.
- Frame width, bit order and optional even parity are parameters. Single-frame and burst (drain-all) transmit modes are selected at run time.
- Sits between the result/memory output mux and the DataOut pin. clkTx is the frequency-divider output, sampled in the clk domain.

Parameters:
- WIDTH, 32, data bits per frame (≥2).
- DEPTH, 4, FIFO depth in frames (power of two, ≥2).
- PARITY_EN, 0, 1 appends one even-parity bit after the data bits.
- MSB_FIRST, 0, 1 shifts data MSB first; 0 shifts LSB first.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  frame to enqueue.
- sample  input  1  push dataIn into FIFO this cycle.
- startTx  input  1  request transmission.
- burst  input  1  sampled with startTx; 1 = drain whole FIFO back-to-back.
- clkTx  input  1  divided bit clock, synchronous to clk.
- dout  output  1  serial data.
- txBusy  output  1  frame in progress.
- txDone  output  1  one-cycle pulse at end of each frame.
- full  output  1  FIFO holds DEPTH frames.
- empty  output  1  FIFO holds 0 frames.
- level  output  $clog2(DEPTH+1)  frames currently stored.
- overflow  output  1  sticky; a push was dropped.

Behaviour:
- Reset: FIFO emptied, level=0, empty=1, full=0, overflow=0, dout=0, txBusy=0, txDone=0, state=IDLE, clkTx_q=0, burst latch=0. Reset mid-frame aborts the frame immediately; no txDone is issued.
- Push: sample=1 and full=0 writes dataIn at the tail, and level increments next cycle. If sample=1 while full=1, the write is dropped and overflow=1 until reset. full is the registered value; a same-cycle pop does not make room.
- Bit tick: tick = clkTx & ~clkTx_q, where clkTx_q is clkTx registered on clk. At most one bit advance per tick.
- Frame length: FB = WIDTH + PARITY_EN. Parity bit = XOR of the data bits (even parity).
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: dout=0, txBusy=0. startTx=1 and empty=0 → LOAD, latching burst. startTx with empty=1 is ignored. startTx outside IDLE is ignored.
- LOAD (1 cycle): pop the FIFO head into the shift register, compute parity, bitCnt=0, txBusy=1 → SHIFT. A tick in LOAD is ignored.
- SHIFT: dout = current bit, valid from the first SHIFT cycle. Each tick advances to the next bit. The tick on bit FB-1 → DONE.
- DONE (1 cycle): txDone=1, txBusy=1, dout=0. If burst latch=1 and empty=0 → LOAD; otherwise → IDLE.
- Burst: gap between frames is exactly 2 clk cycles (DONE, LOAD). Frames pushed during a burst are included in it.
- Simultaneous push and pop in LOAD: both take effect, level unchanged. Pointers wrap modulo DEPTH.
- Latency: startTx cycle N → first data bit on dout at cycle N+2.
- Frame duration: DONE is entered on the cycle after the FB-th tick.

Decomposition:
- Package serial_tx_pkg holds the state encoding constants (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3) and a parity/frame-length helper function.
- One sub-module, tx_frame_fifo (WIDTH, DEPTH): synchronous FIFO with push, pop, full, empty, level and overflow.
- Shifter, tick detector and FSM stay in serial_tx_buffered.

Test Plan:
- WIDTH=8, MSB_FIRST=0, PARITY_EN=0. Push 0xA5, then startTx with burst=0 → dout bits 1,0,1,0,0,1,0,1, one per tick. txDone pulses once after the 8th tick; txBusy low one cycle later; level 1→0.
- WIDTH=8, MSB_FIRST=1, PARITY_EN=1. Push 0x07 → bits 0,0,0,0,0,1,1,1, then parity 1; 9 ticks before txDone.
- DEPTH=4. Push 0x11, 0x22, 0x33, 0x44, then 0x55 → full=1, level=4, overflow=1, 0x55 never transmitted. Burst start → four frames in order, four txDone pulses, exactly 2 clk cycles DONE→SHIFT between frames, empty=1 at the end.
- startTx with empty=1 → stays IDLE, txBusy=0, dout=0. startTx during SHIFT → ignored, and only one frame is sent.
- Assert reset mid-frame after 3 ticks → next cycle dout=0, txBusy=0, level=0, overflow=0, no txDone. A new push+start then transmits normally.
- clkTx held high for 10 clk cycles → exactly one bit advance. A tick coinciding with the LOAD cycle → ignored; the first bit is still held until the next tick.
